// File: rtl/bilinear_pkg.sv
// Shared widths, constants and the channel-slice helper for the bilinear interpolation pipe.
package bilinear_pkg;
   localparam int PIXW  = 8;
   localparam int NCH   = 3;
   localparam int FRACW = 8;
   localparam int HW    = PIXW + FRACW;
   localparam int VW    = PIXW + 2 * FRACW;
   localparam int PW    = NCH * PIXW;

   // One extra bit so a full weight of 1.0 is representable.
   localparam logic [FRACW:0] ONE = (FRACW + 1)'(1) << FRACW;

   function automatic logic [PIXW-1:0] ch_slice(input logic [PW-1:0] pix, input int c);
      return pix[c*PIXW +: PIXW];
   endfunction
endpackage

// File: rtl/bilinear_lerp.sv
// Combinational 1-D weighted sum a*(ONE-w) + b*w, widened by FRACW bits.
module bilinear_lerp
   import bilinear_pkg::*;
#(
   parameter int IW = 8
) (
   input  logic [IW-1:0]       a_i,
   input  logic [IW-1:0]       b_i,
   input  logic [FRACW-1:0]    w_i,
   output logic [IW+FRACW-1:0] y_o
);
   logic [FRACW:0] wc;

   assign wc = ONE - {1'b0, w_i};

   // The true result never exceeds (2^IW-1)*ONE, so it fits the output width exactly.
   assign y_o = (IW + FRACW)'(a_i) * (IW + FRACW)'(wc)
              + (IW + FRACW)'(b_i) * (IW + FRACW)'(w_i);
endmodule

// File: rtl/bilinear_interp_pipe.sv
// 3-stage valid/ready bilinear interpolator: horizontal lerp, vertical lerp, normalise.
// BILINEAR_ROUND_EN selects round-half-up normalisation; otherwise the result is truncated.
module bilinear_interp_pipe
   import bilinear_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PW-1:0]    p00,
   input  logic [PW-1:0]    p01,
   input  logic [PW-1:0]    p10,
   input  logic [PW-1:0]    p11,
   input  logic [FRACW-1:0] wx,
   input  logic [FRACW-1:0] wy,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PW-1:0]    out_pix,
   output logic             out_last
);
   logic             s1_valid_q, s2_valid_q, out_valid_q;
   logic             s1_last_q, s2_last_q, out_last_q;
   logic [FRACW-1:0] s1_wy_q;
   logic [HW-1:0]    h0_d [NCH];
   logic [HW-1:0]    h1_d [NCH];
   logic [HW-1:0]    h0_q [NCH];
   logic [HW-1:0]    h1_q [NCH];
   logic [VW-1:0]    v_d  [NCH];
   logic [VW-1:0]    v_q  [NCH];
   logic [PW-1:0]    out_pix_d, out_pix_q;
   logic             s1_adv, s2_adv, s3_adv;

   assign s3_adv   = !out_valid_q || out_ready;
   assign s2_adv   = !s2_valid_q || s3_adv;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = reset_n && s1_adv;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [VW:0]   rsum;
      logic [PIXW:0] r;
      logic          unused_frac;

      bilinear_lerp #(.IW(PIXW)) u_h0 (
         .a_i (ch_slice(p00, c)),
         .b_i (ch_slice(p01, c)),
         .w_i (wx),
         .y_o (h0_d[c])
      );
      bilinear_lerp #(.IW(PIXW)) u_h1 (
         .a_i (ch_slice(p10, c)),
         .b_i (ch_slice(p11, c)),
         .w_i (wx),
         .y_o (h1_d[c])
      );
      bilinear_lerp #(.IW(HW)) u_v (
         .a_i (h0_q[c]),
         .b_i (h1_q[c]),
         .w_i (s1_wy_q),
         .y_o (v_d[c])
      );

`ifdef BILINEAR_ROUND_EN
      localparam logic [VW:0] RND = (VW + 1)'(1) << (2 * FRACW - 1);
      assign rsum = {1'b0, v_q[c]} + RND;
`else
      assign rsum = {1'b0, v_q[c]};
`endif
      assign r           = rsum[VW:2*FRACW];
      assign unused_frac = ^rsum[2*FRACW-1:0];
      // Saturation cannot trigger for legal weights; kept as a guard.
      assign out_pix_d[c*PIXW +: PIXW] = r[PIXW] ? {PIXW{1'b1}} : r[PIXW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_pix_q   <= '0;
      end else begin
         if (s1_adv) s1_valid_q <= in_valid;
         if (s2_adv) s2_valid_q <= s1_valid_q;
         if (s3_adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
               out_pix_q  <= out_pix_d;
               out_last_q <= s2_last_q;
            end
         end
      end
   end

   // Datapath registers carry no reset; the valids alone decide what is live.
   always_ff @(posedge clk) begin
      if (in_valid && s1_adv) begin
         for (int c = 0; c < NCH; c++) begin
            h0_q[c] <= h0_d[c];
            h1_q[c] <= h1_d[c];
         end
         s1_wy_q   <= wy;
         s1_last_q <= in_last;
      end
      if (s1_valid_q && s2_adv) begin
         for (int c = 0; c < NCH; c++) v_q[c] <= v_d[c];
         s2_last_q <= s1_last_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;
   assign out_last  = out_last_q;
endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// Directed-vector bench for bilinear_interp_pipe with hand-computed expectations.
module tb_bilinear_interp_pipe;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] p00, p01, p10, p11;
   logic [7:0]  wx, wy;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_pix;
   logic        out_last;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bilinear_interp_pipe dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p00       (p00),
      .p01       (p01),
      .p10       (p10),
      .p11       (p11),
      .wx        (wx),
      .wy        (wy),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pix   (out_pix),
      .out_last  (out_last)
   );

   function automatic logic [23:0] beat(input int i);
      return {8'(i * 7 + 1), 8'(192 - i), 8'(i + 16)};
   endfunction

   // Single beat through an empty pipe; reports pixel, last and whether timing matched.
   task automatic apply_one(input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] c, input logic [23:0] d,
                            input logic [7:0] x, input logic [7:0] y,
                            output logic [23:0] pix, output logic last,
                            output logic acc_ok, output logic lat_ok);
      @(negedge clk);
      in_valid = 1'b1; p00 = a; p01 = b; p10 = c; p11 = d;
      wx = x; wy = y; in_last = 1'b1; out_ready = 1'b1;
      #1 acc_ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      #1 lat_ok = !out_valid;
      @(posedge clk);
      @(negedge clk);
      #1 lat_ok = lat_ok && !out_valid;
      @(posedge clk);
      @(negedge clk);
      #1 lat_ok = lat_ok && out_valid;
      pix  = out_pix;
      last = out_last;
      @(posedge clk);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
      p00 = '0; p01 = '0; p10 = '0; p11 = '0; wx = '0; wy = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_pix !== 24'h0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b l=%b pix=%h want 0 0 000000", out_valid, out_last, out_pix);
      end
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL release_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_midpoint;
      logic [23:0] pix;
      logic        last, acc, lat;
      apply_one(24'hAA2010, 24'hAA2030, 24'hAA2050, 24'hAA2070, 8'h80, 8'h80, pix, last, acc, lat);
      total++;
      if (acc !== 1'b1) begin bad++; $display("FAIL mid_accept: got in_ready=%b want 1", acc); end
      total++;
      if (lat !== 1'b1) begin bad++; $display("FAIL mid_latency: got ok=%b want 1 (valid only 3 cycles after accept)", lat); end
      total++;
      if (pix !== 24'hAA2040) begin bad++; $display("FAIL mid_pix: got %h want aa2040", pix); end
      total++;
      if (last !== 1'b1) begin bad++; $display("FAIL mid_last: got %b want 1", last); end
   endtask

   task automatic test_corners;
      logic [23:0] pix;
      logic        last, acc, lat;
      apply_one(24'h123456, 24'h654321, 24'hABCDEF, 24'h0F0F0F, 8'h00, 8'h00, pix, last, acc, lat);
      total++;
      if (pix !== 24'h123456 || lat !== 1'b1) begin bad++; $display("FAIL corner_w0: got %h want 123456", pix); end
      apply_one(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 8'hFF, 8'hFF, pix, last, acc, lat);
      total++;
      if (pix !== 24'hFFFFFF) begin bad++; $display("FAIL corner_full: got %h want ffffff", pix); end
      apply_one(24'h000000, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF, 8'hFF, 8'h00, pix, last, acc, lat);
      total++;
      if (pix !== 24'h0000FE) begin bad++; $display("FAIL corner_wx_max: got %h want 0000fe", pix); end
      apply_one(24'h000010, 24'hFFFFFF, 24'h000030, 24'hFFFFFF, 8'h00, 8'h80, pix, last, acc, lat);
      total++;
      if (pix !== 24'h000020) begin bad++; $display("FAIL vertical_mid: got %h want 000020", pix); end
      apply_one(24'h000000, 24'h000080, 24'h000000, 24'h000000, 8'h40, 8'h00, pix, last, acc, lat);
      total++;
      if (pix !== 24'h000020) begin bad++; $display("FAIL quarter_wx: got %h want 000020", pix); end
   endtask

   task automatic test_rounding;
      logic [23:0] pix, want;
      logic        last, acc, lat;
`ifdef BILINEAR_ROUND_EN
      want = 24'h000001;
`else
      want = 24'h000000;
`endif
      apply_one(24'h000000, 24'h000001, 24'h000000, 24'h000000, 8'h80, 8'h00, pix, last, acc, lat);
      total++;
      if (pix !== want) begin bad++; $display("FAIL rounding: got %h want %h", pix, want); end
   endtask

   task automatic test_backpressure;
      int          sent = 0, got = 0, inflight = 0, cyc = 0;
      logic        stall_prev = 1'b0, acc, hs, exp_ir;
      logic [23:0] held = '0;
      while (got < 10 && cyc < 200) begin
         @(negedge clk);
         in_valid  = (sent < 10);
         p00 = beat(sent); p01 = ~beat(sent); p10 = beat(sent) ^ 24'h5A5A5A; p11 = 24'hFFFFFF;
         wx = 8'h00; wy = 8'h00;
         in_last   = (sent == 9);
         out_ready = (cyc % 3 == 0);
         #1;
         exp_ir = !(inflight == 3 && !out_ready);
         total++;
         if (in_ready !== exp_ir) begin
            bad++;
            $display("FAIL bp_in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ir);
         end
         if (stall_prev) begin
            total++;
            if (out_valid !== 1'b1 || out_pix !== held) begin
               bad++;
               $display("FAIL bp_hold cyc=%0d: got v=%b pix=%h want v=1 pix=%h", cyc, out_valid, out_pix, held);
            end
         end
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            total++;
            if (out_pix !== beat(got) || out_last !== (got == 9)) begin
               bad++;
               $display("FAIL bp_beat%0d: got pix=%h last=%b want pix=%h last=%b",
                        got, out_pix, out_last, beat(got), (got == 9));
            end
            got++;
         end
         stall_prev = out_valid && !out_ready;
         held       = out_pix;
         @(posedge clk);
         if (acc) begin sent++; inflight++; end
         if (hs) inflight--;
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      total++;
      if (got != 10 || sent != 10 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_count: got received=%0d sent=%0d trailing_valid=%b want 10 10 0", got, sent, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic exp_v;
      out_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         in_valid = (c < 16);
         p00 = beat(c + 20); p01 = 24'h0; p10 = 24'h0; p11 = 24'h0;
         wx = 8'h00; wy = 8'h00;
         in_last = (c == 15);
         #1;
         if (c < 16) begin
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready); end
         end
         exp_v = (c >= 3 && c < 19);
         total++;
         if (out_valid !== exp_v) begin
            bad++;
            $display("FAIL b2b_valid c=%0d: got %b want %b", c, out_valid, exp_v);
         end else if (exp_v) begin
            total++;
            if (out_pix !== beat(c - 3 + 20) || out_last !== (c == 18)) begin
               bad++;
               $display("FAIL b2b_data c=%0d: got pix=%h last=%b want pix=%h last=%b",
                        c, out_pix, out_last, beat(c - 3 + 20), (c == 18));
            end
         end
         @(posedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic stale;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b1; p00 = beat(c + 50); p01 = 24'h0; p10 = 24'h0; p11 = 24'h0;
         wx = 8'h00; wy = 8'h00; in_last = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rm_full: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
      end
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || out_pix !== 24'h0) begin
         bad++;
         $display("FAIL rm_flush: got v=%b pix=%h want 0 000000", out_valid, out_pix);
      end
      reset_n   = 1'b1;
      out_ready = 1'b1;
      stale     = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         @(negedge clk);
         #1 if (out_valid !== 1'b0) stale = 1'b1;
      end
      total++;
      if (stale !== 1'b0) begin bad++; $display("FAIL rm_stale: got stale beat=%b want 0", stale); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_midpoint();
      test_corners();
      test_rounding();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
